spi_frame_tx: RTL and testbench
===============================

// Module: spi_frame_tx
// PURPOSE
//  Parametrised SPI master transmitter; successor to the fixed 9-bit SPI sender on the maxima path.
//  Pops words from a FIFO read port and serialises each MSB-first on mosi. Groups FRAME_WORDS words
//  per cs-low frame (one frame per FFT maxima set). sclk, mode and word width are set by parameters.
//  Runs entirely on the system clock; sclk is derived internally, so no second clock domain on the
//  read side.
// PARAMETERS
//  DATA_W      9   payload bits per word (FIFO rdata width)
//  FRAME_WORDS 16  words sent per cs-low frame
//  CLK_DIV     6   clk cycles per sclk half-period; >=2 (50 MHz / 12 = 4.17 MHz)
//  CPOL        0   sclk idle level
//  CPHA        0   0: sample on leading edge, change on trailing; 1: change on leading, sample on trailing
//  RD_LAT      1   clk cycles from fifo_rd_en to valid fifo_rdata; 1..3
//  CS_IDLE     8   minimum clk cycles cs stays high between frames
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous active-low reset
//  fifo_empty   in   1       FIFO empty flag
//  fifo_rd_en   out  1       one-cycle FIFO pop strobe
//  fifo_rdata   in   DATA_W  FIFO read data, valid RD_LAT cycles after fifo_rd_en
//  sclk         out  1       SPI clock
//  mosi         out  1       SPI data out
//  cs           out  1       chip select, active low
//  busy         out  1       high from frame start until CS_IDLE ends
//  frame_done   out  1       one-cycle pulse when cs rises after the last word
// BEHAVIOUR
//  Reset (async, any state): cs=1, sclk=CPOL, mosi=0, fifo_rd_en=0, busy=0, frame_done=0,
//   word_cnt=0, bit_cnt=0, state=IDLE. All outputs registered.
//  FSM: IDLE -> FETCH -> WAIT_RD -> SETUP -> SHIFT -> (FETCH | TAIL) ; TAIL -> HOLD -> IDLE.
//   IDLE:    if !fifo_empty, go to FETCH and set busy.
//   FETCH:   if !fifo_empty, pulse fifo_rd_en for 1 cycle, then WAIT_RD. If empty, stall here:
//            cs unchanged, sclk at CPOL, no pop issued. fifo_rd_en is never high while fifo_empty=1.
//   WAIT_RD: wait RD_LAT cycles; load shift register with fifo_rdata (plus parity bit if enabled).
//            cs goes low on the load of word 0.
//   SETUP:   mosi = MSB. Hold CLK_DIV cycles (tCSS / setup before first edge).
//   SHIFT:   2*WORD_BITS sclk half-periods, each CLK_DIV cycles.
//            CPHA=0: shift on trailing edges; no shift after the final trailing edge.
//            CPHA=1: shift on leading edges, except the first.
//   After the last edge, sclk returns to CPOL. Then increment word_cnt.
//   After SHIFT: if word_cnt<FRAME_WORDS, go to FETCH (cs held low; inter-word gap 1+RD_LAT+CLK_DIV
//   cycles with sclk idle). Otherwise go to TAIL.
//   TAIL:    wait CLK_DIV cycles, then cs=1, frame_done=1 for one cycle, word_cnt=0.
//   HOLD:    CS_IDLE cycles with cs high; busy drops on exit to IDLE.
//  WORD_BITS = DATA_W (+1 with parity). bit_cnt width = $clog2(2*WORD_BITS+1).
//  word_cnt width = $clog2(FRAME_WORDS+1). Divider counter wraps at CLK_DIV-1.
//  FIFO emptying mid-frame: stall in FETCH indefinitely with cs low; no padding, no word dropped.
//  fifo_empty deasserting in the same cycle FETCH is entered: pop that cycle.
//  Reset mid-word: cs rises asynchronously. The partial word is lost and not re-fetched.
//   The next frame starts at word 0.
// CONFIGURATION
//  SPI_PARITY_EN defined: each word is followed by one even-parity bit over DATA_W payload bits
//   (mosi LSB slot); WORD_BITS=DATA_W+1.
//  Undefined: no parity slot; WORD_BITS=DATA_W. All other timing is identical.
// STRUCTURE
//  spi_frame_pkg: state_t enum (IDLE,FETCH,WAIT_RD,SETUP,SHIFT,TAIL,HOLD); function even_parity();
//   localparam helpers for counter widths.
//  Sub-module spi_sclk_gen: CLK_DIV divider with enable. Outputs sclk level plus lead_stb/trail_stb
//   one-cycle strobes. The FSM consumes the strobes.
// TESTING
//  1 Reset: hold rst_n=0 for 20 clk -> cs=1, sclk=0, mosi=0, fifo_rd_en=0, busy=0.
//    Assert rst_n=0 mid-SHIFT -> cs=1 within the same cycle, no clk edge needed.
//  2 Frame: FIFO preloaded with 16 words 0x1A5,0x003,...,0x100 (default params) -> one cs-low window,
//    144 rising sclk edges, decoded words equal the FIFO order, exactly 16 pops, one frame_done.
//  3 Underflow: only 5 words available, 6th written 500 clk later -> cs stays low, sclk idle,
//    no fifo_rd_en while empty; word 6 sent correctly, frame completes at 16.
//  4 Mode 3 (CPOL=1,CPHA=1), word 0x0F0 -> sclk idles high; data sampled on rising edges
//    decodes to 0x0F0.
//  5 SPI_PARITY_EN: words 0x1FF, 0x001, 0x003 -> 10-bit slots with parity bits 1, 1, 0;
//    frame has 16*10 edges.
//  6 Back-to-back: 32 words queued -> two frames with cs high >= CS_IDLE=8 clk between them.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: shared types and helpers for the SPI frame transmitter.
// Holds the FSM state enum, counter-width helpers and the even-parity function.
// Optional feature macro: SPI_PARITY_EN (adds one parity bit per word).
package spi_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_RD,
    SETUP,
    SHIFT,
    TAIL,
    HOLD
  } state_t;

  // Widest payload the parity helper accepts.
  localparam int PAR_MAX_W = 64;

`ifdef SPI_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // Bits needed to hold the values 0..n.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bit that makes the total count of ones even.
  function automatic logic even_parity(
    input logic [PAR_MAX_W-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/spi_frame_tx_sclk_gen.sv
// spi_sclk_gen: sclk divider with enable for spi_frame_tx.
// Ports: clk, rst_n (async low), i_en; o_sclk level, o_lead_stb / o_trail_stb
// one-cycle strobes coincident with each sclk edge. Idle level is CPOL.
module spi_sclk_gen
  import spi_frame_pkg::*;
#(
  parameter int   CLK_DIV = 6,
  parameter logic CPOL    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_sclk,
  output logic o_lead_stb,
  output logic o_trail_stb
);

  localparam int DW = cnt_w(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_MAX =
    DW'(CLK_DIV - 1);

  logic [DW-1:0] r_cnt;
  logic          r_sclk;
  logic          r_lead;
  logic          r_trail;

  // The counter parks at DIV_MAX while disabled so the
  // first enabled cycle produces the leading edge at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= DIV_MAX;
      r_sclk  <= CPOL;
      r_lead  <= 1'b0;
      r_trail <= 1'b0;
    end else begin
      r_lead  <= 1'b0;
      r_trail <= 1'b0;
      if (!i_en) begin
        r_cnt  <= DIV_MAX;
        r_sclk <= CPOL;
      end else if (r_cnt == DIV_MAX) begin
        r_cnt  <= '0;
        r_sclk <= ~r_sclk;
        if (r_sclk == CPOL) begin
          r_lead <= 1'b1;
        end else begin
          r_trail <= 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_sclk      = r_sclk;
  assign o_lead_stb  = r_lead;
  assign o_trail_stb = r_trail;

endmodule

// File: rtl/spi_frame_tx.sv
// spi_frame_tx: SPI master that pops FIFO words and sends FRAME_WORDS per cs-low frame.
// Ports: clk, rst_n, fifo_empty/fifo_rd_en/fifo_rdata (FIFO read side),
// sclk, mosi, cs (active low), busy, frame_done. Macro SPI_PARITY_EN adds a parity slot.
module spi_frame_tx
  import spi_frame_pkg::*;
#(
  parameter int   DATA_W      = 9,
  parameter int   FRAME_WORDS = 16,
  parameter int   CLK_DIV     = 6,
  parameter logic CPOL        = 1'b0,
  parameter logic CPHA        = 1'b0,
  parameter int   RD_LAT      = 1,
  parameter int   CS_IDLE     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              sclk,
  output logic              mosi,
  output logic              cs,
  output logic              busy,
  output logic              frame_done
);

  localparam int WORD_BITS = DATA_W + PAR_BITS;
  localparam int BW = $clog2(2 * WORD_BITS + 1);
  localparam int WW = $clog2(FRAME_WORDS + 1);
  localparam int TW =
    cnt_w(max3(CLK_DIV, CS_IDLE, RD_LAT));

  localparam logic [BW-1:0] LAST_EDGE =
    BW'(2 * WORD_BITS - 1);
  localparam logic [WW-1:0] LAST_WORD =
    WW'(FRAME_WORDS - 1);
  localparam logic [TW-1:0] T_RD   = TW'(RD_LAT);
  localparam logic [TW-1:0] T_DIV  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] T_IDLE = TW'(CS_IDLE - 1);

  state_t                 r_state;
  logic [WW-1:0]          r_word_cnt;
  logic [BW-1:0]          r_bit_cnt;
  logic [TW-1:0]          r_tmr;
  logic [WORD_BITS-1:0]   r_shreg;
  logic                   r_cs;
  logic                   r_rd_en;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_en;
  logic                   w_sclk;
  logic                   w_lead;
  logic                   w_trail;
  logic                   w_strobe;
  logic                   w_last_edge;
  logic                   w_shift;
  logic [WORD_BITS-1:0]   w_load;

`ifdef SPI_PARITY_EN
  assign w_load = {
    fifo_rdata,
    even_parity(PAR_MAX_W'(fifo_rdata))
  };
`else
  assign w_load = fifo_rdata;
`endif

  assign w_en        = (r_state == SHIFT);
  assign w_strobe    = w_lead | w_trail;
  assign w_last_edge = (r_bit_cnt == LAST_EDGE);

  // r_bit_cnt counts edges already seen. CPHA=0 moves
  // data on trailing edges but not after the last one;
  // CPHA=1 moves data on every leading edge but the first.
  assign w_shift = CPHA
    ? (w_lead && (r_bit_cnt != '0))
    : (w_trail && !w_last_edge);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_sclk_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (w_en),
    .o_sclk      (w_sclk),
    .o_lead_stb  (w_lead),
    .o_trail_stb (w_trail)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_word_cnt <= '0;
      r_bit_cnt  <= '0;
      r_tmr      <= '0;
      r_shreg    <= '0;
      r_cs       <= 1'b1;
      r_rd_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (!fifo_empty) begin
            r_busy  <= 1'b1;
            r_state <= FETCH;
          end
        end
        FETCH: begin
          if (!fifo_empty) begin
            r_rd_en <= 1'b1;
            r_tmr   <= '0;
            r_state <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          // Pop is on the bus during the first cycle here,
          // so data is valid once r_tmr reaches RD_LAT.
          if (r_tmr == T_RD) begin
            r_shreg <= w_load;
            if (r_word_cnt == '0) begin
              r_cs <= 1'b0;
            end
            r_tmr   <= '0;
            r_state <= SETUP;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        SETUP: begin
          if (r_tmr == T_DIV) begin
            r_tmr     <= '0;
            r_bit_cnt <= '0;
            r_state   <= SHIFT;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        SHIFT: begin
          if (w_strobe) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_shift) begin
              r_shreg <= {r_shreg[WORD_BITS-2:0], 1'b0};
            end
            if (w_last_edge) begin
              r_bit_cnt  <= '0;
              r_word_cnt <= r_word_cnt + 1'b1;
              if (r_word_cnt == LAST_WORD) begin
                r_state <= TAIL;
              end else begin
                r_state <= FETCH;
              end
            end
          end
        end
        TAIL: begin
          if (r_tmr == T_DIV) begin
            r_tmr      <= '0;
            r_cs       <= 1'b1;
            r_done     <= 1'b1;
            r_word_cnt <= '0;
            r_state    <= HOLD;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        HOLD: begin
          if (r_tmr == T_IDLE) begin
            r_tmr   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fifo_rd_en = r_rd_en;
  assign sclk       = w_sclk;
  assign mosi       = r_shreg[WORD_BITS-1];
  assign cs         = r_cs;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_spi_frame_tx.sv
// tb_spi_frame_tx: directed bench for spi_frame_tx (mode 0 and mode 3 instances).
// FIFO models feed each DUT; sclk-edge monitors decode mosi into received words.
module tb_spi_frame_tx;
  import spi_frame_pkg::*;

  localparam int WB = 9 + PAR_BITS;
  localparam logic [15:0] WMASK = 16'((1 << WB) - 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // ---------------- DUT 1: mode 0 ----------------
  logic [8:0] mem1 [64];
  logic [5:0] wp1 = '0;
  logic [5:0] rp1 = '0;
  logic [8:0] rd1 = '0;
  logic e1, re1, sclk1, mosi1, cs1, busy1, fd1;
  assign e1 = (wp1 == rp1);

  spi_frame_tx u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (e1),
    .fifo_rd_en (re1),
    .fifo_rdata (rd1),
    .sclk       (sclk1),
    .mosi       (mosi1),
    .cs         (cs1),
    .busy       (busy1),
    .frame_done (fd1)
  );

  int pops1 = 0, viol1 = 0, fdc1 = 0;
  int edges1 = 0, falls1 = 0, nb1 = 0;
  int run1 = 0, gap1 = 0;
  logic [15:0] sh1 = '0;
  logic [15:0] rx1 [$];

  always @(posedge clk) begin
    if (re1) begin
      rd1 <= mem1[rp1];
      rp1 <= rp1 + 6'd1;
    end
  end

  always @(posedge clk) begin
    if (re1) begin
      pops1++;
      if (e1) viol1++;
    end
    if (fd1) fdc1++;
  end

  always @(posedge sclk1 or posedge cs1) begin
    if (cs1 === 1'b0) begin
      sh1 = {sh1[14:0], mosi1};
      nb1++;
      edges1++;
      if (nb1 == WB) begin
        rx1.push_back(sh1 & WMASK);
        nb1 = 0;
      end
    end else begin
      nb1 = 0;
    end
  end

  always @(negedge cs1) falls1++;

  always @(negedge clk) begin
    if (cs1 === 1'b1) begin
      run1++;
    end else begin
      if (run1 > 0) gap1 = run1;
      run1 = 0;
    end
  end

  // ---------------- DUT 2: mode 3 ----------------
  logic [8:0] mem2 [64];
  logic [5:0] wp2 = '0;
  logic [5:0] rp2 = '0;
  logic [8:0] rd2 = '0;
  logic e2, re2, sclk2, mosi2, cs2, busy2, fd2;
  assign e2 = (wp2 == rp2);

  spi_frame_tx #(
    .CPOL (1'b1),
    .CPHA (1'b1)
  ) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (e2),
    .fifo_rd_en (re2),
    .fifo_rdata (rd2),
    .sclk       (sclk2),
    .mosi       (mosi2),
    .cs         (cs2),
    .busy       (busy2),
    .frame_done (fd2)
  );

  int fdc2 = 0, edges2 = 0, nb2 = 0;
  logic [15:0] sh2 = '0;
  logic [15:0] rx2 [$];

  always @(posedge clk) begin
    if (re2) begin
      rd2 <= mem2[rp2];
      rp2 <= rp2 + 6'd1;
    end
  end

  always @(posedge clk) if (fd2) fdc2++;

  always @(posedge sclk2 or posedge cs2) begin
    if (cs2 === 1'b0) begin
      sh2 = {sh2[14:0], mosi2};
      nb2++;
      edges2++;
      if (nb2 == WB) begin
        rx2.push_back(sh2 & WMASK);
        nb2 = 0;
      end
    end else begin
      nb2 = 0;
    end
  end

  // ---------------- helpers ----------------
  logic [8:0] fw [16] = '{
    9'h1A5, 9'h003, 9'h1FF, 9'h001,
    9'h155, 9'h0AA, 9'h123, 9'h0F0,
    9'h00F, 9'h1E1, 9'h081, 9'h17E,
    9'h0C3, 9'h13C, 9'h055, 9'h100
  };
  logic [8:0] bw [32];

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [15:0] slot(
    input logic [8:0] w
  );
`ifdef SPI_PARITY_EN
    return {6'b0, w, ^w};
`else
    return {7'b0, w};
`endif
  endfunction

  task automatic push1(input logic [8:0] w);
    mem1[wp1] = w;
    wp1 = wp1 + 6'd1;
  endtask

  task automatic push2(input logic [8:0] w);
    mem2[wp2] = w;
    wp2 = wp2 + 6'd1;
  endtask

  task automatic wait_fd1(input int tgt, input int bud);
    int k = 0;
    while (fdc1 < tgt && k < bud) begin
      @(negedge clk);
      k++;
    end
    if (fdc1 < tgt) chk("timeout_fd1", 32'(fdc1), 32'(tgt));
  endtask

  task automatic wait_idle1(input int bud);
    int k = 0;
    while (busy1 !== 1'b0 && k < bud) begin
      @(negedge clk);
      k++;
    end
    if (busy1 !== 1'b0) chk("timeout_idle1", 32'(busy1), 0);
  endtask

  function automatic logic [31:0] rxw1(input int i);
    return (i < rx1.size()) ? 32'(rx1[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rxw2(input int i);
    return (i < rx2.size()) ? 32'(rx2[i]) : 32'hFFFF_FFFF;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int b_pop, b_fd, b_edge, b_fall, b_viol, e_snap;
    int k, bad;

    // Reset values
    rst_n = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", 32'(cs1), 1);
    chk("rst_sclk", 32'(sclk1), 0);
    chk("rst_mosi", 32'(mosi1), 0);
    chk("rst_rd_en", 32'(re1), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_done", 32'(fd1), 0);
    chk("rst_sclk_m3", 32'(sclk2), 1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Full frame, preloaded
    b_pop = pops1; b_fd = fdc1;
    b_edge = edges1; b_fall = falls1;
    rx1.delete();
    for (int i = 0; i < 16; i++) push1(fw[i]);
    wait_fd1(b_fd + 1, 4000);
    wait_idle1(100);
    chk("frm_nwords", 32'(rx1.size()), 16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("frm_w%0d", i), rxw1(i), 32'(slot(fw[i])));
`ifdef SPI_PARITY_EN
    chk("frm_edges", 32'(edges1 - b_edge), 160);
    chk("par_003", rxw1(1), 32'h006);
    chk("par_1ff", rxw1(2), 32'h3FF);
    chk("par_001", rxw1(3), 32'h003);
`else
    chk("frm_edges", 32'(edges1 - b_edge), 144);
    chk("hand_003", rxw1(1), 32'h003);
    chk("hand_1ff", rxw1(2), 32'h1FF);
    chk("hand_001", rxw1(3), 32'h001);
`endif
    chk("frm_pops", 32'(pops1 - b_pop), 16);
    chk("frm_done", 32'(fdc1 - b_fd), 1);
    chk("frm_cs_falls", 32'(falls1 - b_fall), 1);
    chk("frm_cs_end", 32'(cs1), 1);
    chk("frm_sclk_end", 32'(sclk1), 0);

    // Underflow after 5 words
    b_pop = pops1; b_fd = fdc1;
    b_fall = falls1; b_viol = viol1;
    rx1.delete();
    for (int i = 0; i < 5; i++) push1(fw[i]);
    k = 0;
    while (rx1.size() < 5 && k < 1500) begin
      @(negedge clk);
      k++;
    end
    chk("uf_first5", 32'(rx1.size()), 5);
    e_snap = edges1;
    repeat (500) @(negedge clk);
    chk("uf_cs_low", 32'(cs1), 0);
    chk("uf_sclk_idle", 32'(sclk1), 0);
    chk("uf_no_edges", 32'(edges1 - e_snap), 0);
    chk("uf_busy", 32'(busy1), 1);
    chk("uf_pops5", 32'(pops1 - b_pop), 5);
    for (int i = 5; i < 16; i++) push1(fw[i]);
    wait_fd1(b_fd + 1, 3000);
    wait_idle1(100);
    chk("uf_nwords", 32'(rx1.size()), 16);
    chk("uf_word6", rxw1(5), 32'(slot(9'h0AA)));
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (rxw1(i) !== 32'(slot(fw[i]))) bad++;
    chk("uf_words", 32'(bad), 0);
    chk("uf_pops", 32'(pops1 - b_pop), 16);
    chk("uf_rd_empty", 32'(viol1 - b_viol), 0);
    chk("uf_cs_falls", 32'(falls1 - b_fall), 1);

    // Mode 3 on the second instance
    b_edge = edges2; b_fd = fdc2;
    rx2.delete();
    push2(9'h0F0);
    for (int i = 1; i < 16; i++) push2(fw[i]);
    k = 0;
    while (fdc2 < b_fd + 1 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk("m3_done", 32'(fdc2 - b_fd), 1);
`ifdef SPI_PARITY_EN
    chk("m3_w0", rxw2(0), 32'h1E0);
    chk("m3_edges", 32'(edges2 - b_edge), 160);
`else
    chk("m3_w0", rxw2(0), 32'h0F0);
    chk("m3_edges", 32'(edges2 - b_edge), 144);
`endif
    chk("m3_nwords", 32'(rx2.size()), 16);
    chk("m3_w7", rxw2(7), 32'(slot(9'h0F0)));
    chk("m3_sclk_idle", 32'(sclk2), 1);

    // Back-to-back frames
    b_pop = pops1; b_fd = fdc1;
    rx1.delete();
    for (int i = 0; i < 32; i++) begin
      bw[i] = 9'(i * 37 + 5);
      push1(bw[i]);
    end
    wait_fd1(b_fd + 2, 8000);
    wait_idle1(100);
    chk("b2b_done", 32'(fdc1 - b_fd), 2);
    chk("b2b_nwords", 32'(rx1.size()), 32);
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (rxw1(i) !== 32'(slot(bw[i]))) bad++;
    chk("b2b_words", 32'(bad), 0);
    chk("b2b_pops", 32'(pops1 - b_pop), 32);
    chk("b2b_gap_ge8", 32'(gap1 >= 8), 1);

    // Async reset in the middle of a word
    b_edge = edges1;
    rx1.delete();
    for (int i = 0; i < 16; i++) push1(fw[i]);
    k = 0;
    while (edges1 - b_edge < 5 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("mid_edges", 32'(edges1 - b_edge >= 5), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", 32'(cs1), 1);
    chk("mid_rst_sclk", 32'(sclk1), 0);
    chk("mid_rst_busy", 32'(busy1), 0);
    repeat (3) @(negedge clk);
    wp1 = rp1;
    rx1.delete();
    b_fd = fdc1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 16; i++) push1(bw[i]);
    wait_fd1(b_fd + 1, 4000);
    wait_idle1(100);
    chk("post_nwords", 32'(rx1.size()), 16);
    chk("post_w0", rxw1(0), 32'(slot(bw[0])));
    chk("post_w15", rxw1(15), 32'(slot(bw[15])));

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
